clause_solution_checker: RTL and testbench



---
 rtl/sat_pkg.sv | 21 ++
 rtl/clause_literal_eval.sv | 36 +++
 rtl/clause_solution_checker.sv | 176 +++++++++++++++++
 tb/tb_clause_solution_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared types and constants for the WalkSAT clause-table cluster: literal/clause
// word layouts and the solution-checker FSM encoding.
package sat_pkg;

  localparam int unsigned DefaultNsat = 3;
  localparam int unsigned DefaultLitW = 8;

  // MSB of a literal selects negation; the remaining bits are the variable index.
  localparam int unsigned NegBit = DefaultLitW - 1;

  typedef logic [DefaultLitW-1:0]             literal_t;
  typedef logic [DefaultNsat*DefaultLitW-1:0] clause_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } chk_state_e;

endpackage

// File: rtl/clause_literal_eval.sv
// Combinational clause evaluation: OR of NSAT literals, each the variable value bit
// XOR its negation bit. Variable indices outside the value vector read as false.
module clause_literal_eval
  import sat_pkg::*;
#(
  parameter int unsigned NSAT          = DefaultNsat,
  parameter int unsigned LIT_W         = DefaultLitW,
  parameter int unsigned NUM_VARIABLES = 2048
) (
  input  logic [NSAT*LIT_W-1:0]   clause_i,
  input  logic [NUM_VARIABLES-1:0] var_bits_i,
  output logic                     clause_sat_o
);

  localparam int unsigned NegPos = LIT_W - 1;
  localparam int unsigned IdxW   = LIT_W - 1;
  localparam int unsigned VarAw  = (NUM_VARIABLES > 1) ? $clog2(NUM_VARIABLES) : 1;
  // One spare bit so NUM_VARIABLES itself is representable in the range compare.
  localparam int unsigned WideW  = ((IdxW > VarAw) ? IdxW : VarAw) + 1;

  logic [NSAT-1:0] lit_val;

  for (genvar i = 0; i < NSAT; i++) begin : g_lit
    logic [LIT_W-1:0] lit;
    logic [WideW-1:0] idx;
    logic             in_range;

    assign lit        = clause_i[i*LIT_W +: LIT_W];
    assign idx        = WideW'(lit[IdxW-1:0]);
    assign in_range   = idx < WideW'(NUM_VARIABLES);
    assign lit_val[i] = in_range ? (lit[NegPos] ^ var_bits_i[idx[VarAw-1:0]]) : 1'b0;
  end

  assign clause_sat_o = |lit_val;

endmodule

// File: rtl/clause_solution_checker.sv
// Reads clauses 0..N-1 from the clause table after the solver finishes and reports
// SAT/UNSAT, unsatisfied count and (with CHECKER_FIRST_UNSAT_EN) the first failing index.
module clause_solution_checker
  import sat_pkg::*;
#(
  parameter int unsigned NSAT          = DefaultNsat,
  parameter int unsigned LIT_W         = DefaultLitW,
  parameter int unsigned NUM_VARIABLES = 2048,
  parameter int unsigned NUM_CLAUSES   = 2048
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             abort_i,
  input  logic [$clog2(NUM_CLAUSES+1)-1:0] num_clauses_i,
  input  logic [NUM_VARIABLES-1:0]         var_bits_i,
  output logic                             ct_rd_en_o,
  output logic [$clog2(NUM_CLAUSES)-1:0]   ct_rd_addr_o,
  input  logic [NSAT*LIT_W-1:0]            ct_rd_data_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             sat_o,
  output logic [$clog2(NUM_CLAUSES+1)-1:0] unsat_count_o,
  output logic                             first_unsat_valid_o,
  output logic [$clog2(NUM_CLAUSES)-1:0]   first_unsat_o
);

  localparam int unsigned CntW  = $clog2(NUM_CLAUSES + 1);
  localparam int unsigned AddrW = $clog2(NUM_CLAUSES);

  chk_state_e       state_q, state_d;
  logic [CntW-1:0]  num_q, num_d;
  logic [AddrW-1:0] issue_q, issue_d;
  logic             dvalid_q, dvalid_d;
  logic [CntW-1:0]  unsat_q, unsat_d;
  logic             sat_q, sat_d;

  logic             clause_sat;
  logic             rd_en;
  logic             clear_res;
  logic             accept;
  logic             last_issue;
  logic [CntW-1:0]  num_clamped;
  logic [CntW-1:0]  unsat_inc;

  clause_literal_eval #(
    .NSAT          (NSAT),
    .LIT_W         (LIT_W),
    .NUM_VARIABLES (NUM_VARIABLES)
  ) u_eval (
    .clause_i     (ct_rd_data_i),
    .var_bits_i   (var_bits_i),
    .clause_sat_o (clause_sat)
  );

  assign num_clamped = (num_clauses_i > CntW'(NUM_CLAUSES)) ? CntW'(NUM_CLAUSES)
                                                            : num_clauses_i;
  assign last_issue  = (CntW'(issue_q) + CntW'(1)) == num_q;

  // A returned word only counts if the check is not being abandoned this cycle.
  assign accept      = dvalid_q & ~abort_i;
  assign unsat_inc   = unsat_q + CntW'(accept & ~clause_sat);
  assign unsat_d     = clear_res ? '0 : unsat_inc;
  assign dvalid_d    = rd_en & ~abort_i;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    issue_d   = issue_q;
    sat_d     = sat_q;
    rd_en     = 1'b0;
    clear_res = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          num_d     = num_clamped;
          issue_d   = '0;
          clear_res = 1'b1;
          sat_d     = (num_clamped == '0);
          state_d   = (num_clamped == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        rd_en = 1'b1;
        if (abort_i) begin
          clear_res = 1'b1;
          sat_d     = 1'b0;
          state_d   = StIdle;
        end else if (last_issue) begin
          state_d = StDrain;
        end else begin
          issue_d = issue_q + AddrW'(1);
        end
      end
      StDrain: begin
        if (abort_i) begin
          clear_res = 1'b1;
          sat_d     = 1'b0;
          state_d   = StIdle;
        end else begin
          sat_d   = (unsat_inc == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      num_q    <= '0;
      issue_q  <= '0;
      dvalid_q <= 1'b0;
      unsat_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      issue_q  <= issue_d;
      dvalid_q <= dvalid_d;
      unsat_q  <= unsat_d;
      sat_q    <= sat_d;
    end
  end

`ifdef CHECKER_FIRST_UNSAT_EN
  logic [AddrW-1:0] eval_addr_q;
  logic [AddrW-1:0] first_q, first_d;
  logic             first_valid_q, first_valid_d;

  always_comb begin
    first_d       = first_q;
    first_valid_d = first_valid_q;
    if (clear_res) begin
      first_d       = '0;
      first_valid_d = 1'b0;
    end else if (accept && !clause_sat && !first_valid_q) begin
      first_d       = eval_addr_q;
      first_valid_d = 1'b1;
    end
  end

  // eval_addr_q tracks the address whose data is on ct_rd_data_i this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eval_addr_q   <= '0;
      first_q       <= '0;
      first_valid_q <= 1'b0;
    end else begin
      if (rd_en) eval_addr_q <= issue_q;
      first_q       <= first_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign first_unsat_o       = first_q;
  assign first_unsat_valid_o = first_valid_q;
`else
  assign first_unsat_o       = '0;
  assign first_unsat_valid_o = 1'b0;
`endif

  assign ct_rd_en_o    = rd_en;
  assign ct_rd_addr_o  = rd_en ? issue_q : '0;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign sat_o         = sat_q;
  assign unsat_count_o = unsat_q;

endmodule

// File: tb/tb_clause_solution_checker.sv
// Randomized bench for clause_solution_checker: a clause-table RAM, a per-run model of
// the check result and a cycle timeline, compared against the DUT on every cycle.
module tb_clause_solution_checker;
  import sat_pkg::*;

  localparam int unsigned NC = 2048;
  localparam int unsigned NV = 2048;
  localparam int unsigned CW = 12;
  localparam int unsigned AW = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CW-1:0]     num_clauses = '0;
  logic [NV-1:0]     var_bits = '0;
  logic              ct_rd_en;
  logic [AW-1:0]     ct_rd_addr;
  clause_word_t      ct_rd_data = '0;
  logic              busy, done, sat, fuv;
  logic [CW-1:0]     unsat_count;
  logic [AW-1:0]     first_unsat;

  clause_word_t mem [NC];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // Expectation state written by the driver, read by the compare process.
  int mode = 0;
  int t0 = 0;
  int exp_n = 0;
  int abort_k = 0;
  int exp_cnt = 0;
  int exp_first = 0;

  clause_solution_checker dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .start_i             (start),
    .abort_i             (abort),
    .num_clauses_i       (num_clauses),
    .var_bits_i          (var_bits),
    .ct_rd_en_o          (ct_rd_en),
    .ct_rd_addr_o        (ct_rd_addr),
    .ct_rd_data_i        (ct_rd_data),
    .busy_o              (busy),
    .done_o              (done),
    .sat_o               (sat),
    .unsat_count_o       (unsat_count),
    .first_unsat_valid_o (fuv),
    .first_unsat_o       (first_unsat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clause table: one-cycle read latency, garbage on the data bus when not reading.
  always @(posedge clk) ct_rd_data <= ct_rd_en ? mem[ct_rd_addr] : clause_word_t'($urandom);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input int n, input logic [NV-1:0] vb,
                                output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int c = 0; c < n; c++) begin
      bit any;
      any = 1'b0;
      for (int l = 0; l < int'(DefaultNsat); l++) begin
        logic [7:0]  lit;
        logic [10:0] vi;
        lit = mem[c][l*8 +: 8];
        vi  = {4'b0, lit[6:0]};
        if (int'(vi) < int'(NV)) any = any | (vb[vi] ^ lit[7]);
      end
      if (!any) begin
        if (cnt == 0) first = c;
        cnt++;
      end
    end
  endfunction

  function automatic logic [NV-1:0] rand_vb();
    logic [NV-1:0] v;
    for (int i = 0; i < int'(NV / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Per-cycle comparison against the expected timeline of the current run.
  always @(posedge clk) begin
    int k, dk;
    bit zero, res_chk;
    logic e_en, e_busy, e_done, e_sat, e_fv;
    logic [AW-1:0] e_addr, e_first;
    logic [CW-1:0] e_cnt;
    #1;
    k    = cyc - t0 + 1;
    dk   = (exp_n == 0) ? 1 : exp_n + 2;
    zero = (mode == 0) ||
           (abort_k != 0 && exp_n != 0 && abort_k <= exp_n + 1 && k > abort_k);
    e_en = 1'b0; e_addr = '0; e_busy = 1'b0; e_done = 1'b0; e_sat = 1'b0;
    e_cnt = '0; e_fv = 1'b0; e_first = '0;
    res_chk = 1'b1;
    if (!zero) begin
      e_cnt = CW'(exp_cnt);
      e_sat = (exp_cnt == 0);
`ifdef CHECKER_FIRST_UNSAT_EN
      e_fv    = (exp_cnt != 0);
      e_first = (exp_cnt != 0) ? AW'(exp_first) : '0;
`endif
      if (k <= dk) begin
        e_en    = (k >= 1) && (k <= exp_n);
        e_addr  = e_en ? AW'(k - 1) : '0;
        e_busy  = 1'b1;
        e_done  = (k == dk);
        res_chk = (k == dk);
        if (!res_chk) e_sat = 1'b0;
      end
    end
    chk("rd_en", ct_rd_en, e_en);
    chk("rd_addr", ct_rd_addr, e_addr);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("sat", sat, e_sat);
    if (res_chk) begin
      chk("unsat_count", unsat_count, e_cnt);
      chk("first_valid", fuv, e_fv);
      chk("first_unsat", first_unsat, e_first);
    end
  end

  task automatic begin_run(input int n_in, input logic [NV-1:0] vb, input int abort_at);
    int n;
    @(negedge clk);
    n           = (n_in > int'(NC)) ? int'(NC) : n_in;
    var_bits    = vb;
    num_clauses = CW'(n_in);
    exp_n       = n;
    model(n, vb, exp_cnt, exp_first);
    abort_k     = abort_at;
    t0          = cyc + 1;
    mode        = 1;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic run(input int n_in, input logic [NV-1:0] vb, input int abort_at,
                     input int start_at);
    begin_run(n_in, vb, abort_at);
    for (int c = 1; c <= exp_n + 4; c++) begin
      start = (c == start_at);
      abort = (c == abort_at);
      if (c == start_at) num_clauses = CW'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, ct_rd_en, 1'b0);
    chk({tag, "_rd_addr"}, ct_rd_addr, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_sat"}, sat, 1'b0);
    chk({tag, "_cnt"}, unsat_count, '0);
    chk({tag, "_fv"}, fuv, 1'b0);
    chk({tag, "_first"}, first_unsat, '0);
  endtask

  initial begin
    logic [NV-1:0] vb0, vb2, vb3;
    int mc, mf;
    for (int i = 0; i < int'(NC); i++) mem[i] = clause_word_t'($urandom);
    mem[0] = {8'h07, 8'h82, 8'h05};
    mem[1] = {8'h81, 8'h03, 8'h86};
    mem[2] = {8'h04, 8'h87, 8'h02};
    vb0 = '0;
    vb2 = '0; vb2[2] = 1'b1;
    vb3 = '0; vb3[1] = 1'b1; vb3[2] = 1'b1; vb3[6] = 1'b1;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Hand-derived results for the three reference clauses.
    model(3, vb0, mc, mf);
    chk("model_allzero_cnt", mc, 0);
    model(3, vb2, mc, mf);
    chk("model_var2_cnt", mc, 1);
    chk("model_var2_first", mf, 0);
    model(3, vb3, mc, mf);
    chk("model_var126_cnt", mc, 2);
    chk("model_var126_first", mf, 0);

    run(3, vb0, 0, 0);
    chk("s1_sat", sat, 1'b1);
    run(3, vb2, 0, 0);
    chk("s2_cnt", unsat_count, 12'd1);
    run(3, vb3, 0, 0);
    chk("s3_cnt", unsat_count, 12'd2);
    chk("s3_sat", sat, 1'b0);
    run(0, vb2, 0, 0);
    chk("n0_sat", sat, 1'b1);
    run(1, vb2, 0, 0);

    // Abort in RUN, then a run that ignores a mid-RUN start pulse.
    run(3, vb0, 2, 0);
    check_all_zero("after_abort");
    run(3, vb2, 0, 2);
    // Abort in DRAIN (takes effect), in DONE and in IDLE (both ignored).
    run(5, rand_vb(), 6, 0);
    run(4, rand_vb(), 6, 0);
    run(4, rand_vb(), 7, 0);

    // Asynchronous reset in the middle of a run.
    begin_run(10, rand_vb(), 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    mode = 0;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(3, vb3, 0, 0);

    for (int r = 0; r < 14; r++) begin
      for (int i = 3; i < 64; i++) mem[i] = clause_word_t'($urandom);
      run(int'($urandom_range(1, 40)), rand_vb(), 0, 0);
    end

    // Count above the table depth is clamped to the full table.
    run(3000, rand_vb(), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
